// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter with per-requester burst credits.
// The owner keeps the grant for up to weight[owner] accepted transfers, or until
// it drops its request; the next eligible requester then takes over in the same
// cycle, so there are no bubble cycles between bursts.
module wrr_burst_arbiter #(
  parameter int VECTOR_IN = 8,
  parameter int WEIGHT_W  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [VECTOR_IN-1:0]                 request_vector,
  input  logic [VECTOR_IN-1:0][WEIGHT_W-1:0]   weight,
  input  logic                                 grant_ready,
  output logic [VECTOR_IN-1:0]                 grant,
  output logic                                 grant_valid,
  output logic [$clog2(VECTOR_IN)-1:0]         grant_id,
  output logic                                 grant_last
);

  localparam int ID_W = $clog2(VECTOR_IN);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state;
  logic [WEIGHT_W-1:0]  wlat;
  logic [WEIGHT_W-1:0]  cnt;
  logic [ID_W-1:0]      ptr;

  logic [VECTOR_IN-1:0] eligible;
  logic [ID_W-1:0]      next_ptr;
  logic [ID_W-1:0]      pick_start;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_idx;
  logic [WEIGHT_W-1:0]  pick_w;
  logic [VECTOR_IN-1:0] pick_onehot;
  logic                 owner_req;
  logic                 xfer;
  logic                 last_beat;
  logic                 burst_end;

  // A requester competes only while it requests and has a non-zero weight.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < VECTOR_IN; i++) begin
      eligible[i] = request_vector[i] & (weight[i] != '0);
    end
  end

  // Rotating priority search: first eligible index at or after the start point.
  // In IDLE the search starts at ptr; at a burst end it starts just past the
  // current owner, which is the value ptr is being updated to in that cycle.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    next_ptr    = (grant_id == ID_W'(VECTOR_IN - 1)) ? '0 : grant_id + ID_W'(1);
    pick_start  = (state == GRANT) ? next_ptr : ptr;
    pick_found  = 1'b0;
    pick_idx    = '0;
    for (int unsigned k = 0; k < VECTOR_IN; k++) begin
      idx = int'(pick_start) + k;
      if (idx >= VECTOR_IN) begin
        idx = idx - VECTOR_IN;
      end
      if (!pick_found && eligible[idx]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(idx);
      end
    end
    pick_w      = weight[pick_idx];
    pick_onehot = VECTOR_IN'(1) << pick_idx;
  end

  // Transfer accounting for the current owner.
  always_comb begin
    owner_req = request_vector[grant_id];
    xfer      = grant_valid & grant_ready & owner_req;
    last_beat = (cnt == (wlat - WEIGHT_W'(1)));
    burst_end = (xfer & last_beat) | ~owner_req;
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      wlat        <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      grant_last  <= 1'b0;
    end else begin
      if ((state == IDLE) || burst_end) begin
        if (state == GRANT) begin
          ptr <= next_ptr;
        end
        if (pick_found) begin
          state       <= GRANT;
          grant       <= pick_onehot;
          grant_valid <= 1'b1;
          grant_id    <= pick_idx;
          grant_last  <= (pick_w == WEIGHT_W'(1));
          wlat        <= pick_w;
          cnt         <= '0;
        end else begin
          state       <= IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
          grant_id    <= '0;
          grant_last  <= 1'b0;
          cnt         <= '0;
        end
      end else if (xfer) begin
        cnt        <= cnt + WEIGHT_W'(1);
        grant_last <= ((cnt + WEIGHT_W'(1)) == (wlat - WEIGHT_W'(1)));
      end
    end
  end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Bench for wrr_burst_arbiter: fixed vector table, directed corner sequences
// and randomized traffic, all checked against a credit-countdown reference model.
module tb_wrr_burst_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic                clk;
  logic                rst_n;
  logic [N-1:0]        req;
  logic [N-1:0][W-1:0] weight;
  logic                ready;
  logic [N-1:0]        grant;
  logic                grant_valid;
  logic [1:0]          grant_id;
  logic                grant_last;

  int vectors;
  int miscompares;

  // Reference model: active flag, owner, transfers still allowed, rotation start.
  bit m_act;
  int m_own;
  int m_left;
  int m_ptr;

  typedef struct {
    logic [N-1:0]     req;
    logic [N*W-1:0]   w;
    logic             rdy;
    logic             ev;
    logic [1:0]       eid;
    logic             el;
  } vec_t;

  vec_t tbl[12];

  wrr_burst_arbiter #(.VECTOR_IN(N), .WEIGHT_W(W)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .request_vector (req),
    .weight         (weight),
    .grant_ready    (ready),
    .grant          (grant),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .grant_last     (grant_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mpick(int p, logic [N-1:0] elig);
    for (int k = 0; k < N; k++) begin
      if (elig[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_act  = 0;
    m_own  = 0;
    m_left = 0;
    m_ptr  = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    logic [N-1:0] elig;
    bit do_pick;
    bit ended;
    int p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) elig[i] = req[i] && (weight[i] != 0);
    do_pick = 0;
    ended   = 0;
    if (!m_act) begin
      do_pick = 1;
    end else begin
      if (!req[m_own]) begin
        ended = 1;
      end else if (ready) begin
        m_left = m_left - 1;
        if (m_left == 0) ended = 1;
      end
      if (ended) begin
        m_ptr   = (m_own + 1) % N;
        do_pick = 1;
      end
    end
    if (do_pick) begin
      p = mpick(m_ptr, elig);
      if (p < 0) begin
        m_act  = 0;
        m_own  = 0;
        m_left = 0;
      end else begin
        m_act  = 1;
        m_own  = p;
        m_left = int'(weight[p]);
      end
    end
  endtask

  task automatic check(input string name, input logic ev, input logic [1:0] eid, input logic el);
    logic [N-1:0] eg;
    eg = ev ? (N'(1) << eid) : '0;
    vectors++;
    if (grant !== eg || grant_valid !== ev || grant_id !== (ev ? eid : 2'd0) || grant_last !== (ev & el)) begin
      miscompares++;
      $display("FAIL %s @%0t: got grant=%b valid=%b id=%0d last=%b, expected grant=%b valid=%b id=%0d last=%b",
               name, $time, grant, grant_valid, grant_id, grant_last, eg, ev, ev ? eid : 2'd0, ev & el);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_act, 2'(m_own), m_act && (m_left == 1));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("reset_async");
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    req    = '0;
    weight = '0;
    ready  = 1'b0;
    model_reset();
    cycle();
    cycle();
    check_model("reset_state");
    rst_n = 1'b1;

    // Weights {1,2,3,4}, all requesting, always ready.
    tbl[0]  = '{4'b0000, 16'h4321, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[2]  = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd1, 1'b0};
    tbl[3]  = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[4]  = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[5]  = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[6]  = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[7]  = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd3, 1'b0};
    tbl[8]  = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd3, 1'b0};
    tbl[9]  = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd3, 1'b0};
    tbl[10] = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd3, 1'b1};
    tbl[11] = '{4'b1111, 16'h4321, 1'b1, 1'b1, 2'd0, 1'b1};
    for (int k = 0; k < 12; k++) begin
      req    = tbl[k].req;
      weight = tbl[k].w;
      ready  = tbl[k].rdy;
      cycle();
      check($sformatf("table[%0d]", k), tbl[k].ev, tbl[k].eid, tbl[k].el);
    end

    // Zero-weight requester 1 is skipped without a bubble.
    do_reset();
    req = 4'b1111; weight = 16'h4301; ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cycle();
      check_model("skip_zero_weight");
      if (grant_id == 2'd1 && grant_valid) begin
        vectors++;
        miscompares++;
        $display("FAIL skip_zero_weight_id1: got id=1 granted, expected never");
      end
    end

    // Burst of id 2 (w=3) with ready held low for 5 cycles after the first transfer.
    do_reset();
    req = 4'b0100; weight = 16'h3333; ready = 1'b1;
    cycle(); check_model("stall_grant");
    cycle(); check_model("stall_xfer1");
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(); check_model("stall_hold");
    end
    ready = 1'b1;
    req = 4'b0000;
    cycle(); check_model("stall_xfer2");
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      cycle(); check_model("stall_tail");
    end

    // id 0 (w=4) drops its request after two transfers.
    do_reset();
    req = 4'b1111; weight = 16'h2224; ready = 1'b1;
    cycle(); check_model("drop_grant");
    cycle(); check_model("drop_xfer1");
    cycle(); check_model("drop_xfer2");
    req = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      cycle(); check_model("drop_after");
    end

    // Single requester 3 (w=2): back-to-back re-grant, last every second cycle.
    do_reset();
    req = 4'b0000; weight = 16'h2111; ready = 1'b1;
    cycle(); check_model("single_idle");
    req = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      cycle(); check_model("single_req3");
    end

    // Reset asserted mid-burst, then restart from index 0.
    req = 4'b1111; weight = 16'h4444; ready = 1'b1;
    cycle(); check_model("midreset_pre");
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("midreset_async");
    cycle();
    rst_n = 1'b1;
    req = 4'b1110;
    cycle(); check_model("midreset_restart");
    req = 4'b1111;
    cycle(); check_model("midreset_run");

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      req   = N'($urandom) | (($urandom_range(0, 3) == 0) ? 4'b0000 : N'($urandom));
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < N; i++) begin
          weight[i] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 3));
        end
      end
      cycle();
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
